// File: rtl/cpu_pkg.sv
// Shared constants, encodings and enums for the multi-cycle RISC-V control path.
package cpu_pkg;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_R, CL_I, CL_LD, CL_ST, CL_BR, CL_JAL
  } class_t;

  // CL_NONE doubles as the "unknown opcode" result.
  function automatic class_t classify(input logic [6:0] op);
    case (op)
      OP_R:    return CL_R;
      OP_I:    return CL_I;
      OP_LD:   return CL_LD;
      OP_ST:   return CL_ST;
      OP_BR:   return CL_BR;
      OP_JAL:  return CL_JAL;
      default: return CL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu_dec.sv
// Combinational ALU operation decode from instruction class, funct3 and funct7[5].
module cpu_alu_dec
  import cpu_pkg::*;
(
  input  class_t     cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (cls)
      CL_R, CL_I: begin
        case (funct3)
          3'b000:  alu_op = (cls == CL_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      CL_BR:   alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with retire counter and halt.
module cpu_mc_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_INSTR = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_INSTR);

  state_t     state;
  class_t     cls;
  class_t     dec_cls;
  logic [2:0] dec_op;
  logic       retire_now;
  logic       budget_hit;
  state_t     after_retire;
  logic       unused_ins;

  assign unused_ins = &{1'b0, ins[31], ins[29:15], ins[11:7]};

  cpu_alu_dec u_alu_dec (
    .cls      (cls),
    .funct3   (ins[14:12]),
    .funct7_5 (ins[30]),
    .alu_op   (dec_op)
  );

  assign dec_cls    = classify(ins[6:0]);
  assign retire_now = (state == ST_EXEC && cls == CL_BR) ||
                      (state == ST_MEM && cls == CL_ST && dmem_ready) ||
                      (state == ST_WB);
  // Compare one bit wider so a budget equal to the counter's top value still triggers.
  assign budget_hit   = (MAX_INSTR != 0) && (({1'b0, retired} + 1'b1) == MAX_CNT);
  assign after_retire = budget_hit ? ST_HALT : ST_FETCH;

  assign state_dbg = state;
  assign busy      = (state != ST_IDLE) && (state != ST_HALT);
  assign halted    = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cls     <= CL_NONE;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      if (retire_now && !(&retired))
        retired <= retired + 1'b1;
      case (state)
        ST_IDLE:  if (start) state <= ST_FETCH;
        ST_FETCH: if (imem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          if (dec_cls == CL_NONE) begin
            state   <= ST_HALT;
            illegal <= 1'b1;
          end else begin
            cls   <= dec_cls;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cls == CL_BR)                         state <= after_retire;
          else if (cls == CL_LD || cls == CL_ST)    state <= ST_MEM;
          else                                      state <= ST_WB;
        end
        ST_MEM:  if (dmem_ready) state <= (cls == CL_LD) ? ST_WB : after_retire;
        ST_WB:   state <= after_retire;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ALU controls stay applied through MEM and WB so the address/result remain valid.
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_sel    = WB_ALU;
    if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
      alu_src = !(cls == CL_R || cls == CL_BR);
      alu_op  = dec_op;
    end
    case (state)
      ST_FETCH: ir_we = imem_ready;
      ST_EXEC: begin
        if (cls == CL_BR) begin
          pc_we  = 1'b1;
          pc_sel = zero ? PC_BRANCH : PC_PLUS4;
        end
      end
      ST_MEM: begin
        mem_read  = (cls == CL_LD);
        mem_write = (cls == CL_ST);
        pc_we     = (cls == CL_ST) && dmem_ready;
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        pc_sel    = (cls == CL_JAL) ? PC_JUMP : PC_PLUS4;
        wb_sel    = (cls == CL_LD) ? WB_MEM : (cls == CL_JAL) ? WB_PC4 : WB_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Bench for cpu_mc_ctrl: each instruction expands into an expected per-cycle trace.
module tb_cpu_mc_ctrl;

  localparam int MAXI = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ins = '0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        ir_we, pc_we, reg_write, alu_src, mem_read, mem_write;
  logic        busy, halted, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  alu_op, state_dbg;
  logic [15:0] retired;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] wb_sel;
    logic       busy;
    logic       halted;
    logic       illegal;
  } ctl_t;

  logic [31:0] exp_q[$];
  logic [35:0] in_q[$];
  int ntot = 0;
  int nbad = 0;
  int m_ret;
  bit m_ill;
  bit m_halt;

  cpu_mc_ctrl #(.MAX_INSTR(MAXI), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_write(reg_write), .alu_src(alu_src),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .wb_sel(wb_sel), .busy(busy), .halted(halted), .illegal(illegal),
    .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] alu_model(input logic [31:0] w);
    logic [6:0] opc;
    opc = w[6:0];
    if (opc == 7'h63) return 3'b110;
    if (opc == 7'h33 || opc == 7'h13) begin
      case (w[14:12])
        3'b000:  return (opc == 7'h33 && w[30]) ? 3'b110 : 3'b010;
        3'b111:  return 3'b000;
        3'b110:  return 3'b001;
        3'b010:  return 3'b111;
        default: return 3'b010;
      endcase
    end
    return 3'b010;
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      default: w[6:0] = 7'h6F;
    endcase
    return w;
  endfunction

  task automatic push(input ctl_t c, input logic [3:0] iv, input logic [31:0] w);
    exp_q.push_back({c, 16'(m_ret)});
    in_q.push_back({iv, w});
  endtask

  task automatic retire();
    if (m_ret < 65535) m_ret++;
    if (m_ret == MAXI) m_halt = 1;
  endtask

  task automatic build_idle(input int n, input bit go);
    ctl_t c;
    c = '0;
    for (int i = 0; i < n; i++) push(c, {1'b0, rb(), rb(), rb()}, $urandom());
    if (go) push(c, {1'b1, rb(), rb(), rb()}, $urandom());
  endtask

  task automatic build_halt(input int n);
    ctl_t c;
    c = '0;
    c.halted = 1'b1;
    c.illegal = m_ill;
    for (int i = 0; i < n; i++) push(c, {rb(), rb(), rb(), rb()}, $urandom());
  endtask

  // Expected trace of one instruction: fw fetch stalls, dw data stalls, z = ALU zero in EXEC.
  task automatic build_instr(input logic [31:0] w, input int fw, input int dw, input logic z);
    ctl_t c;
    logic [6:0] opc;
    bit is_ld, is_st, is_br, is_jal, known;
    opc = w[6:0];
    is_ld = (opc == 7'h03);
    is_st = (opc == 7'h23);
    is_br = (opc == 7'h63);
    is_jal = (opc == 7'h6F);
    known = is_ld || is_st || is_br || is_jal || opc == 7'h33 || opc == 7'h13;
    c = '0;
    c.busy = 1'b1;
    for (int i = 0; i < fw; i++) push(c, {rb(), 1'b0, rb(), rb()}, w);
    c.ir_we = 1'b1;
    push(c, {rb(), 1'b1, rb(), rb()}, w);
    c.ir_we = 1'b0;
    push(c, {rb(), rb(), rb(), rb()}, w);
    if (!known) begin
      m_ill = 1;
      m_halt = 1;
      return;
    end
    c.alu_src = !(opc == 7'h33 || is_br);
    c.alu_op = alu_model(w);
    if (is_br) begin
      c.pc_we = 1'b1;
      c.pc_sel = z ? 2'b01 : 2'b00;
      push(c, {rb(), rb(), rb(), z}, w);
      retire();
      return;
    end
    push(c, {rb(), rb(), rb(), rb()}, w);
    if (is_ld || is_st) begin
      c.mem_read = is_ld;
      c.mem_write = is_st;
      for (int i = 0; i < dw; i++) push(c, {rb(), rb(), 1'b0, rb()}, w);
      if (is_st) begin
        c.pc_we = 1'b1;
        push(c, {rb(), rb(), 1'b1, rb()}, w);
        retire();
        return;
      end
      push(c, {rb(), rb(), 1'b1, rb()}, w);
      c.mem_read = 1'b0;
    end
    c.reg_write = 1'b1;
    c.pc_we = 1'b1;
    c.pc_sel = is_jal ? 2'b10 : 2'b00;
    c.wb_sel = is_ld ? 2'b01 : is_jal ? 2'b10 : 2'b00;
    push(c, {rb(), rb(), rb(), rb()}, w);
    retire();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {ir_we, pc_we, pc_sel, reg_write, alu_src, alu_op, mem_read, mem_write,
            wb_sel, busy, halted, illegal, retired};
  endfunction

  // Single compare process: drive each cycle's inputs, then check outputs mid-cycle.
  task automatic run_trace(input int max_n);
    logic [35:0] iv;
    logic [31:0] ev;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_n) begin
      iv = in_q.pop_front();
      ev = exp_q.pop_front();
      @(negedge clk);
      {start, imem_ready, dmem_ready, zero} = iv[35:32];
      ins = iv[31:0];
      #2;
      check("cycle", dut_vec(), ev);
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    zero = 1'b0;
    #1;
    check("reset_outputs", dut_vec(), 32'h0);
    check("reset_state", 32'(state_dbg), 32'(cpu_pkg::ST_IDLE));
    m_ret = 0;
    m_ill = 0;
    m_halt = 0;
    exp_q.delete();
    in_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    check("model_add", 32'(alu_model(32'h002081B3)), 32'h2);
    check("model_sub", 32'(alu_model(32'h402081B3)), 32'h6);
    check("model_slt", 32'(alu_model(32'h0020A1B3)), 32'h7);
    build_idle(2, 1'b1);
    run_trace(100);
    build_instr(32'h002081B3, 0, 0, 1'b0);
    check("add_len", 32'(exp_q.size()), 32'd4);
    run_trace(100);
    @(posedge clk); #1;
    check("add_retired", 32'(retired), 32'd1);

    build_instr(32'h402081B3, 0, 0, 1'b0);
    build_instr(32'h0020A1B3, 0, 0, 1'b0);
    build_instr(32'h00208063, 0, 0, 1'b1);
    build_instr(32'h00208063, 0, 0, 1'b0);
    run_trace(100);
    build_instr(32'h0000A183, 0, 3, 1'b0);
    check("lw_len", 32'(exp_q.size()), 32'd8);
    build_instr(32'h0080006F, 0, 0, 1'b0);
    run_trace(100);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      build_idle($urandom_range(0, 2), 1'b1);
      for (int k = 0; k < 10; k++)
        build_instr(rnd_ins(), $urandom_range(0, 2), $urandom_range(0, 3), rb());
      run_trace(1000);
    end

    do_reset();
    build_idle(1, 1'b1);
    for (int k = 0; k < MAXI; k++) build_instr(32'h00108093, $urandom_range(0, 1), 0, 1'b0);
    build_halt(5);
    run_trace(1000);
    check("budget_halted", 32'(halted), 32'd1);
    check("budget_retired", 32'(retired), 32'd11);

    do_reset();
    build_idle(1, 1'b1);
    build_instr(32'h0000007F, 0, 0, 1'b0);
    build_halt(4);
    run_trace(100);
    check("illegal_flag", {30'd0, illegal, halted}, 32'd3);

    do_reset();
    build_idle(0, 1'b1);
    build_instr(32'h0000A183, 0, 10, 1'b0);
    run_trace(6);
    do_reset();
    @(negedge clk); #2;
    check("after_abort", dut_vec(), 32'h0);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
